frame_serializer: RTL and testbench
===================================

FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameter DATAFRAME_WIDTH, default 64, SHALL be the output line width in bits.
REQ-002 Parameter ADC_WIDTH, default 128, SHALL be the ADC FIFO word width, fixed at 2*DATAFRAME_WIDTH.
REQ-003 Parameter LEN_WIDTH, default 12, SHALL be the width of the header dataframe-length field.
REQ-004 Clocking SHALL use one clock with synchronous, active-high reset: ACLK input 1 (clock), ARESET input 1 (synchronous active-high reset).
REQ-005 HF_FIFO_DOUT input 192 SHALL carry the header-footer word: [191:64] header lines 0 and 1, [63:0] footer; first-word-fall-through.
REQ-006 HF_FIFO_EMPTY input 1 SHALL be the header-footer FIFO empty flag, and HF_FIFO_RD_EN output 1 SHALL be the pop strobe.
REQ-007 ADC_FIFO_DOUT input ADC_WIDTH SHALL carry ADC samples; first-word-fall-through.
REQ-008 ADC_FIFO_EMPTY input 1 SHALL be the ADC FIFO empty flag, and ADC_FIFO_RD_EN output 1 SHALL be the pop strobe.
REQ-009 M_AXIS_TDATA output DATAFRAME_WIDTH, M_AXIS_TVALID output 1, M_AXIS_TREADY input 1 and M_AXIS_TLAST output 1 SHALL form the dataframe AXI-Stream master.
REQ-010 FRAME_CNT output 32 SHALL count completed frames.
REQ-011 LEN_ERR output 1 SHALL be a sticky malformed-length flag.

Function
REQ-012 Length field SHALL be header bits HF_FIFO_DOUT[175:164] (LEN_WIDTH), counting 64-bit ADC lines.
REQ-013 FSM SHALL have states IDLE, HDR0, HDR1, ADC_HI, ADC_LO, FOOTER.
REQ-014 Output register: a new beat SHALL load only when M_AXIS_TVALID==0 or (M_AXIS_TVALID & M_AXIS_TREADY).
REQ-015 TDATA, TLAST and TVALID SHALL stay stable while TVALID=1 and TREADY=0.
REQ-016 IDLE with HF_FIFO_EMPTY=0: assert HF_FIFO_RD_EN one cycle, capture all 192 bits, load length into the word counter as ceil(len/2), go to HDR0.
REQ-017 HF_FIFO_RD_EN SHALL never assert in any state other than IDLE.
REQ-018 HDR0 SHALL load header line 0 ([191:128]); latency from HF_FIFO_EMPTY falling in IDLE to TVALID=1 is 2 cycles.
REQ-019 HDR1 SHALL load header line 1 ([127:64]), then go to ADC_HI, or to FOOTER if the word counter is 0.
REQ-020 ADC_HI SHALL load ADC_FIFO_DOUT[127:64], capture [63:0] into a holding register, pulse ADC_FIFO_RD_EN in the same cycle, and decrement the word counter.
REQ-021 ADC_HI with ADC_FIFO_EMPTY=1 SHALL stall with no load and no RD_EN; TVALID drops after the prior beat is accepted.
REQ-022 ADC_LO SHALL load the holding register, then go to ADC_HI if the counter is nonzero, else to FOOTER.
REQ-023 FOOTER SHALL load [63:0] with TLAST=1, then return to IDLE.
REQ-024 TLAST SHALL be 1 only on the footer beat.
REQ-025 A back-to-back frame MAY begin in IDLE on the cycle after the footer is loaded.
REQ-026 Frame length SHALL be len+3 beats when len is even.
REQ-027 len==0 SHALL produce a frame of header0, header1 and footer, with no ADC pop.
REQ-028 Odd len SHALL set LEN_ERR, read ceil(len/2) ADC words and emit len+1 ADC lines.
REQ-029 LEN_ERR SHALL clear only on reset.
REQ-030 FRAME_CNT SHALL increment on footer acceptance (TVALID & TREADY & TLAST) and wrap 0xFFFFFFFF->0.
REQ-031 ADC_FIFO_RD_EN SHALL never assert when ADC_FIFO_EMPTY=1.
REQ-032 HF_FIFO_RD_EN SHALL never assert when HF_FIFO_EMPTY=1.

Reset
REQ-033 ARESET=1 at any edge SHALL force IDLE, TVALID=0, TLAST=0, TDATA=0, both RD_EN=0, FRAME_CNT=0, LEN_ERR=0 and the counter and holding register to 0.
REQ-034 Reset mid-frame SHALL abandon the frame without a footer; no FIFO flush is performed.

Verification
REQ-035 HF word with len=4, 2 ADC words A,B, TREADY=1 -> 7 beats: H0, H1, A[127:64], A[63:0], B[127:64], B[63:0], F; TLAST on beat 7 only; FRAME_CNT=1.
REQ-036 len=4, TREADY toggling 1010... -> identical 7-beat sequence; TDATA stable during each stall; exactly 1 HF pop and 2 ADC pops.
REQ-037 len=4, ADC FIFO empty for 5 cycles after H1 -> TVALID=0 gap, no ADC_FIFO_RD_EN while empty, sequence resumes intact.
REQ-038 len=0 -> 3 beats H0, H1, F; ADC_FIFO_RD_EN never asserts. len=3 -> LEN_ERR=1, 2 ADC pops, 7 beats.
REQ-039 Three frames back-to-back (len=2 each) with TREADY=1 -> 15 contiguous beats, FRAME_CNT=3. FRAME_CNT preset by forcing 0xFFFFFFFF -> wraps to 0 after the next frame.
REQ-040 ARESET asserted during ADC_LO of a len=4 frame -> next cycle TVALID=0, FRAME_CNT=0. After release, the next HF word starts a fresh frame with H0.

Source files
------------

// File: rtl/frame_serializer_if.sv
// Handshake bundle for frame_serializer: header/footer FIFO, ADC FIFO and the
// dataframe AXI-Stream master. "master" is the serializer side.
interface frame_serializer_if #(
    parameter int unsigned DATAFRAME_WIDTH = 64,
    parameter int unsigned ADC_WIDTH       = 2 * DATAFRAME_WIDTH
);
    localparam int unsigned HF_WIDTH = 3 * DATAFRAME_WIDTH;

    logic [HF_WIDTH-1:0]        HF_FIFO_DOUT;
    logic                       HF_FIFO_EMPTY;
    logic                       HF_FIFO_RD_EN;
    logic [ADC_WIDTH-1:0]       ADC_FIFO_DOUT;
    logic                       ADC_FIFO_EMPTY;
    logic                       ADC_FIFO_RD_EN;
    logic [DATAFRAME_WIDTH-1:0] M_AXIS_TDATA;
    logic                       M_AXIS_TVALID;
    logic                       M_AXIS_TREADY;
    logic                       M_AXIS_TLAST;

    modport master (
        input  HF_FIFO_DOUT, HF_FIFO_EMPTY, ADC_FIFO_DOUT, ADC_FIFO_EMPTY, M_AXIS_TREADY,
        output HF_FIFO_RD_EN, ADC_FIFO_RD_EN, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
    );

    modport slave (
        output HF_FIFO_DOUT, HF_FIFO_EMPTY, ADC_FIFO_DOUT, ADC_FIFO_EMPTY, M_AXIS_TREADY,
        input  HF_FIFO_RD_EN, ADC_FIFO_RD_EN, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
    );
endinterface

// File: rtl/frame_serializer.sv
// Serializes header line 0/1, ADC samples (high half first) and a footer from two
// first-word-fall-through FIFOs into one AXI-Stream dataframe per header-footer word.
module frame_serializer #(
    parameter int unsigned DATAFRAME_WIDTH = 64,
    parameter int unsigned ADC_WIDTH       = 2 * DATAFRAME_WIDTH,
    parameter int unsigned LEN_WIDTH       = 12
) (
    input  logic                ACLK,
    input  logic                ARESET,
    frame_serializer_if.master  bus,
    output logic [31:0]         FRAME_CNT,
    output logic                LEN_ERR
);
    localparam int unsigned DW       = DATAFRAME_WIDTH;
    localparam int unsigned HF_WIDTH = 3 * DW;
    localparam int unsigned LEN_LSB  = HF_WIDTH - 16 - LEN_WIDTH;
    localparam int unsigned CNT_W    = 32;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        ADC_HI,
        ADC_LO,
        FOOTER
    } state_t;

    state_t               state;
    logic [HF_WIDTH-1:0]  hf_word;
    logic [DW-1:0]        hold_q;
    logic [LEN_WIDTH-1:0] word_cnt;
    logic [DW-1:0]        tdata_q;
    logic                 tvalid_q;
    logic                 tlast_q;
    logic [CNT_W-1:0]     frame_cnt_q;
    logic                 len_err_q;

    logic                 can_load;
    logic                 hf_pop;
    logic                 adc_pop;
    logic [LEN_WIDTH-1:0] len_field;
    logic [LEN_WIDTH:0]   len_ext;
    logic [LEN_WIDTH-1:0] half_len;

    // Output slot is free when empty or its beat is being accepted this cycle.
    assign can_load  = !tvalid_q || bus.M_AXIS_TREADY;
    assign hf_pop    = !ARESET && (state == IDLE) && !bus.HF_FIFO_EMPTY;
    assign adc_pop   = !ARESET && (state == ADC_HI) && !bus.ADC_FIFO_EMPTY && can_load;
    assign len_field = bus.HF_FIFO_DOUT[LEN_LSB +: LEN_WIDTH];
    assign len_ext   = {1'b0, len_field} + (LEN_WIDTH + 1)'(1);
    assign half_len  = LEN_WIDTH'(len_ext >> 1);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= IDLE;
            hf_word     <= '0;
            hold_q      <= '0;
            word_cnt    <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            frame_cnt_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            if (tvalid_q && bus.M_AXIS_TREADY) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                if (tlast_q) begin
                    frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                end
            end

            // Loads below override the acceptance clear above.
            case (state)
                IDLE: begin
                    if (hf_pop) begin
                        hf_word  <= bus.HF_FIFO_DOUT;
                        word_cnt <= half_len;
                        if (len_field[0]) begin
                            len_err_q <= 1'b1;
                        end
                        state <= HDR0;
                    end
                end
                HDR0: begin
                    if (can_load) begin
                        tdata_q  <= hf_word[HF_WIDTH-1 -: DW];
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                        state    <= HDR1;
                    end
                end
                HDR1: begin
                    if (can_load) begin
                        tdata_q  <= hf_word[2*DW-1 -: DW];
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                        state    <= (word_cnt == '0) ? FOOTER : ADC_HI;
                    end
                end
                ADC_HI: begin
                    if (adc_pop) begin
                        tdata_q  <= bus.ADC_FIFO_DOUT[ADC_WIDTH-1 -: DW];
                        hold_q   <= bus.ADC_FIFO_DOUT[DW-1:0];
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                        word_cnt <= word_cnt - LEN_WIDTH'(1);
                        state    <= ADC_LO;
                    end
                end
                ADC_LO: begin
                    if (can_load) begin
                        tdata_q  <= hold_q;
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                        state    <= (word_cnt != '0) ? ADC_HI : FOOTER;
                    end
                end
                FOOTER: begin
                    if (can_load) begin
                        tdata_q  <= hf_word[DW-1:0];
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.HF_FIFO_RD_EN  = hf_pop;
    assign bus.ADC_FIFO_RD_EN = adc_pop;
    assign bus.M_AXIS_TDATA   = tdata_q;
    assign bus.M_AXIS_TVALID  = tvalid_q;
    assign bus.M_AXIS_TLAST   = tlast_q;
    assign FRAME_CNT          = frame_cnt_q;
    assign LEN_ERR            = len_err_q;
endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: queue-based FIFO models and a transaction-level
// expected-beat scoreboard, plus directed scenarios pinned with literal values.
module tb_frame_serializer;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 128;
    localparam int unsigned LW = 12;
    localparam int unsigned HW = 192;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] FRAME_CNT;
    logic        LEN_ERR;

    frame_serializer_if #(.DATAFRAME_WIDTH(DW), .ADC_WIDTH(AW)) bus ();

    frame_serializer #(.DATAFRAME_WIDTH(DW), .ADC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .bus       (bus.master),
        .FRAME_CNT (FRAME_CNT),
        .LEN_ERR   (LEN_ERR)
    );

    always #5 ACLK = ~ACLK;

    logic [HW-1:0] hf_q[$];
    logic [AW-1:0] adc_q[$];
    logic [DW:0]   exp_q[$];
    logic [DW:0]   got_q[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          hf_pops = 0;
    int          adc_pops = 0;
    int          rdy_mode = 0;
    logic        rdy = 1'b1;
    logic        adc_block = 1'b0;
    logic        arst = 1'b1;
    logic [31:0] exp_cnt = '0;
    logic        exp_len_err = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_arst = 1'b0;
    logic [DW:0] prev_beat = '0;

    task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected beats follow directly from the header-footer word and the ADC words.
    task automatic push_raw(input logic [HW-1:0] hf, input logic [AW-1:0] words[$]);
        hf_q.push_back(hf);
        exp_q.push_back({1'b0, hf[191:128]});
        exp_q.push_back({1'b0, hf[127:64]});
        foreach (words[i]) begin
            adc_q.push_back(words[i]);
            exp_q.push_back({1'b0, words[i][127:64]});
            exp_q.push_back({1'b0, words[i][63:0]});
        end
        exp_q.push_back({1'b1, hf[63:0]});
    endtask

    task automatic push_frame(input int len);
        logic [HW-1:0] hf;
        logic [AW-1:0] words[$];
        hf = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        hf[175:164] = LW'(len);
        for (int k = 0; k < (len + 1) / 2; k++) begin
            words.push_back({$urandom, $urandom, $urandom, $urandom});
        end
        push_raw(hf, words);
    endtask

    // One clock: drive inputs after the falling edge, then check what the next rising edge sees.
    task automatic step();
        logic [DW:0] e;
        @(negedge ACLK);
        ARESET = arst;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = ~rdy;
            default: begin
                rdy       = 1'($urandom_range(0, 1));
                adc_block = ($urandom_range(0, 3) == 0);
            end
        endcase
        bus.M_AXIS_TREADY  = rdy;
        bus.HF_FIFO_EMPTY  = (hf_q.size() == 0);
        bus.HF_FIFO_DOUT   = (hf_q.size() != 0) ? hf_q[0] : '0;
        bus.ADC_FIFO_EMPTY = adc_block || (adc_q.size() == 0);
        bus.ADC_FIFO_DOUT  = (adc_q.size() != 0) ? adc_q[0] : '0;
        #1;
        cyc++;
        if (prev_arst) begin
            check("reset_tvalid", HW'(bus.M_AXIS_TVALID), '0);
            check("reset_tlast_tdata", HW'({bus.M_AXIS_TLAST, bus.M_AXIS_TDATA}), '0);
        end
        check("frame_cnt", HW'(FRAME_CNT), HW'(exp_cnt));
        check("len_err", HW'(LEN_ERR), HW'(exp_len_err));
        if (prev_stall) begin
            check("stall_stable", HW'({bus.M_AXIS_TVALID, bus.M_AXIS_TLAST, bus.M_AXIS_TDATA}),
                  HW'({1'b1, prev_beat}));
        end
        if (ARESET) begin
            check("reset_rd_en", HW'({bus.HF_FIFO_RD_EN, bus.ADC_FIFO_RD_EN}), '0);
            exp_q.delete();
            exp_cnt     = '0;
            exp_len_err = 1'b0;
        end else begin
            if (bus.HF_FIFO_RD_EN) begin
                check("hf_pop_nonempty", HW'(bus.HF_FIFO_EMPTY), '0);
                if (hf_q.size() != 0) begin
                    if (hf_q[0][164]) exp_len_err = 1'b1;
                    void'(hf_q.pop_front());
                end
                hf_pops++;
            end
            if (bus.ADC_FIFO_RD_EN) begin
                check("adc_pop_nonempty", HW'(bus.ADC_FIFO_EMPTY), '0);
                if (adc_q.size() != 0) void'(adc_q.pop_front());
                adc_pops++;
            end
            if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
                got_q.push_back({bus.M_AXIS_TLAST, bus.M_AXIS_TDATA});
                check("beat_expected", HW'(exp_q.size() != 0), HW'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat", HW'({bus.M_AXIS_TLAST, bus.M_AXIS_TDATA}), HW'(e));
                    if (e[DW]) exp_cnt = exp_cnt + 32'd1;
                end
            end
        end
        prev_stall = bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY && !ARESET;
        prev_beat  = {bus.M_AXIS_TLAST, bus.M_AXIS_TDATA};
        prev_arst  = ARESET;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        check("drain", HW'(exp_q.size()), '0);
        step();
        step();
    endtask

    task automatic wait_beats(input int target, input int bound);
        int n = 0;
        while (got_q.size() < target && n < bound) begin
            step();
            n++;
        end
        check("wait_beats", HW'(got_q.size() >= target), HW'(1));
    endtask

    localparam logic [63:0] H0 = 64'hAAAA_0040_00C0_FFEE;  // length field = 4
    localparam logic [63:0] H1 = 64'hBBBB_1234_5678_9ABC;
    localparam logic [63:0] FT = 64'hF00D_0000_F00D_0001;
    localparam logic [127:0] WA = 128'hA1A1_A1A1_0000_0001_A2A2_A2A2_0000_0002;
    localparam logic [127:0] WB = 128'hB1B1_B1B1_0000_0003_B2B2_B2B2_0000_0004;

    initial begin
        logic [AW-1:0] ws[$];
        int h0, a0, f0, gaps;
        logic [HW-1:0] hf;

        ARESET = 1'b1;
        bus.M_AXIS_TREADY  = 1'b1;
        bus.HF_FIFO_EMPTY  = 1'b1;
        bus.HF_FIFO_DOUT   = '0;
        bus.ADC_FIFO_EMPTY = 1'b1;
        bus.ADC_FIFO_DOUT  = '0;

        // Reset state
        repeat (3) step();
        arst = 1'b0;
        step();
        check("init_tvalid", HW'(bus.M_AXIS_TVALID), '0);
        check("init_tdata", HW'(bus.M_AXIS_TDATA), '0);
        check("init_frame_cnt", HW'(FRAME_CNT), '0);
        check("init_len_err", HW'(LEN_ERR), '0);

        // len=4, TREADY=1: latency and the exact seven-beat sequence
        ws = '{WA, WB};
        got_q.delete();
        push_raw({H0, H1, FT}, ws);
        step();
        check("latency_c0", HW'(bus.M_AXIS_TVALID), '0);
        step();
        check("latency_c1", HW'(bus.M_AXIS_TVALID), '0);
        step();
        check("latency_c2", HW'(bus.M_AXIS_TVALID), HW'(1));
        drain(100);
        check("f1_beats", HW'(got_q.size()), HW'(7));
        check("f1_h0", HW'(got_q[0]), HW'({1'b0, 64'hAAAA_0040_00C0_FFEE}));
        check("f1_a_hi", HW'(got_q[2]), HW'({1'b0, 64'hA1A1_A1A1_0000_0001}));
        check("f1_a_lo", HW'(got_q[3]), HW'({1'b0, 64'hA2A2_A2A2_0000_0002}));
        check("f1_b_lo", HW'(got_q[5]), HW'({1'b0, 64'hB2B2_B2B2_0000_0004}));
        check("f1_footer", HW'(got_q[6]), HW'({1'b1, 64'hF00D_0000_F00D_0001}));
        check("f1_frame_cnt", HW'(FRAME_CNT), HW'(1));

        // len=4 with TREADY toggling
        rdy_mode = 1;
        h0 = hf_pops; a0 = adc_pops;
        got_q.delete();
        push_raw({H0, H1, FT}, ws);
        drain(200);
        rdy_mode = 0;
        check("toggle_beats", HW'(got_q.size()), HW'(7));
        check("toggle_hf_pops", HW'(hf_pops - h0), HW'(1));
        check("toggle_adc_pops", HW'(adc_pops - a0), HW'(2));

        // len=4 with the ADC FIFO held empty after the headers
        adc_block = 1'b1;
        got_q.delete();
        push_frame(4);
        wait_beats(2, 50);
        gaps = 0;
        repeat (5) begin
            step();
            if (!bus.M_AXIS_TVALID) gaps++;
        end
        check("adc_gap_seen", HW'(gaps >= 4), HW'(1));
        adc_block = 1'b0;
        drain(100);
        check("adc_gap_beats", HW'(got_q.size()), HW'(7));

        // len=0: headers and footer only
        a0 = adc_pops;
        got_q.delete();
        push_frame(0);
        drain(100);
        check("len0_beats", HW'(got_q.size()), HW'(3));
        check("len0_adc_pops", HW'(adc_pops - a0), '0);
        check("len0_last", HW'(got_q[2][DW]), HW'(1));

        // len=3: odd length flags error and rounds up
        a0 = adc_pops;
        got_q.delete();
        push_frame(3);
        drain(100);
        check("len3_err", HW'(LEN_ERR), HW'(1));
        check("len3_adc_pops", HW'(adc_pops - a0), HW'(2));
        check("len3_beats", HW'(got_q.size()), HW'(7));

        // Three back-to-back len=2 frames
        f0 = int'(FRAME_CNT);
        got_q.delete();
        repeat (3) push_frame(2);
        drain(200);
        check("b2b_beats", HW'(got_q.size()), HW'(15));
        check("b2b_frames", HW'(int'(FRAME_CNT) - f0), HW'(3));

        // Frame counter wrap
        force dut.frame_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        push_frame(2);
        drain(100);
        check("wrap_frame_cnt", HW'(FRAME_CNT), '0);

        // Randomized frames with random backpressure and ADC starvation
        rdy_mode = 2;
        for (int i = 0; i < 25; i++) push_frame(int'($urandom_range(0, 9)));
        drain(8000);
        rdy_mode = 0;
        adc_block = 1'b0;

        // Reset in the middle of the ADC section abandons the frame
        got_q.delete();
        push_raw({H0, H1, FT}, ws);
        wait_beats(2, 50);
        arst = 1'b1;
        step();
        arst = 1'b0;
        hf_q.delete();
        adc_q.delete();
        step();
        check("midrst_frame_cnt", HW'(FRAME_CNT), '0);
        check("midrst_len_err", HW'(LEN_ERR), '0);
        got_q.delete();
        hf = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        hf[175:164] = 12'd2;
        ws = '{{$urandom, $urandom, $urandom, $urandom}};
        push_raw(hf, ws);
        drain(100);
        check("midrst_fresh_h0", HW'(got_q[0]), HW'({1'b0, hf[191:128]}));
        check("midrst_fresh_beats", HW'(got_q.size()), HW'(5));
        check("midrst_frame_cnt_after", HW'(FRAME_CNT), HW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
